// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Converts a 14-bit binary value to four BCD digits using a sequential
//   shift-add-3 (double-dabble) FSM. The result is held in display registers
//   and time-multiplexed onto a shared 4-bit digit bus with active-low anodes.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, a scanned digit that is 0, and whose more-significant digits
//   are also 0, is driven as 4'hF (all segments off). d0 is never blanked.
//
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (2..2^20)
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst    synchronous active-high reset
//   i_value  unsigned value to display
//   i_load   single-cycle convert request (ignored while o_busy)
//   o_busy   conversion in progress
//   o_done   one-cycle pulse after the display registers update
//   o_ovf    last accepted value exceeded 9999 and was clamped
//   o_digit  BCD code of the enabled digit
//   o_an     active-low one-hot anode enables, o_an[0] = ones digit
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [13:0] i_value,
    input  logic        i_load,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_ovf,
    output logic [3:0]  o_digit,
    output logic [3:0]  o_an
);

    localparam int unsigned PsW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PsW-1:0] PsLast = PsW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [13:0] r_bin;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_ovf_pend;
    logic        r_done;
    logic        r_ovf;
    logic [15:0] r_disp;
    logic [PsW-1:0] r_ps;
    logic [1:0]  r_idx;

    logic [13:0] w_clamped;
    logic [15:0] w_bcd_adj;
    logic [15:0] w_bcd_sh;
    logic [13:0] w_bin_sh;
    logic [3:0]  w_sel;

    assign w_clamped = (i_value > 14'd9999) ? 14'd9999 : i_value;

    // Add-3 correction on every nibble >= 5 before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign {w_bcd_sh, w_bin_sh} = {w_bcd_adj, r_bin} << 1;

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (i_load) w_state_next = StShift;
            StShift:  if (r_cnt == 4'd13) w_state_next = StCommit;
            StCommit: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Conversion datapath and display registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_disp     <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_load) begin
                        r_bin      <= w_clamped;
                        r_ovf_pend <= (i_value > 14'd9999);
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                    end
                end
                StShift: begin
                    r_bcd <= w_bcd_sh;
                    r_bin <= w_bin_sh;
                    r_cnt <= r_cnt + 4'd1;
                end
                StCommit: begin
                    r_disp <= r_bcd;
                    r_ovf  <= r_ovf_pend;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Free-running scan, independent of the conversion FSM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ps  <= '0;
            r_idx <= '0;
        end else if (r_ps == PsLast) begin
            r_ps  <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_ps <= r_ps + 1'b1;
        end
    end

    assign w_sel  = r_disp[{r_idx, 2'b00} +: 4];
    assign o_an   = ~(4'b0001 << r_idx);
    assign o_busy = (r_state != StIdle);
    assign o_done = r_done;
    assign o_ovf  = r_ovf;

`ifdef LEADING_ZERO_BLANK_EN
    logic w_blank;

    always_comb begin
        w_blank = 1'b0;
        unique case (r_idx)
            2'd3:    w_blank = (r_disp[15:12] == 4'd0);
            2'd2:    w_blank = (r_disp[15:8] == 8'd0);
            2'd1:    w_blank = (r_disp[15:4] == 12'd0);
            default: w_blank = 1'b0;
        endcase
    end

    assign o_digit = w_blank ? 4'hF : w_sel;
`else
    assign o_digit = w_sel;
`endif

endmodule
